// File: rtl/vga_frame_scanout_pkg.sv
// Shared definitions for the VGA framebuffer scan-out block.
// Holds the 640x480@60Hz timing constants and the framebuffer geometry.
// Also holds the colour type and the row*160+col address helper.
package vga_frame_scanout_pkg;

  // Framebuffer geometry
  localparam int H_RES       = 160;
  localparam int V_RES       = 120;
  localparam int SCALE_SHIFT = 2;
  localparam int COLOUR_W    = 3;

  // 640x480@60Hz timing, in pixel-clock units
  localparam int H_VIS  = 640;
  localparam int H_FP   = 16;
  localparam int H_SYNC = 96;
  localparam int H_TOT  = 800;
  localparam int V_VIS  = 480;
  localparam int V_FP   = 10;
  localparam int V_SYNC = 2;
  localparam int V_TOT  = 525;

  localparam int FB_DEPTH = 19200;
  localparam int ADDR_W   = 15;
  localparam int CNT_W    = 10;

  typedef logic [COLOUR_W-1:0] colour_t;
  typedef logic [ADDR_W-1:0]   fb_addr_t;

  localparam colour_t BLACK = 3'b000;
  localparam colour_t WHITE = 3'b111;

  // Sync/blank bundle that travels down the read pipeline alongside the pixel data
  typedef struct packed {
    logic hs;
    logic vs;
    logic blank_n;
  } vid_ctl_t;

  // row*160 + col built from two shifts so no multiplier is inferred
  function automatic fb_addr_t fb_addr(input logic [7:0] row, input logic [7:0] col);
    return {row, 7'b0000000} + {2'b00, row, 5'b00000} + {7'b0000000, col};
  endfunction

endpackage

// File: rtl/vga_frame_scanout_fb_dual_port_ram.sv
// 19200 x 3 simple dual-port framebuffer RAM with a registered read.
// A read and a write to the same address on the same clock edge return the old contents.
// Ports:
//   clk      common clock
//   i_we     write enable
//   i_waddr  write address
//   i_wdata  write data
//   i_raddr  read address, sampled every clk
//   o_rdata  read data, one clk after i_raddr
module fb_dual_port_ram
  import vga_frame_scanout_pkg::*;
(
  input  logic     clk,
  input  logic     i_we,
  input  fb_addr_t i_waddr,
  input  colour_t  i_wdata,
  input  fb_addr_t i_raddr,
  output colour_t  o_rdata
);

  colour_t r_mem [0:FB_DEPTH-1];
  colour_t r_rdata;

  // Write port; contents are deliberately left without a reset so the array maps to block RAM
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Registered read port; sits in its own process so reads see pre-write data
  always_ff @(posedge clk) begin
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/vga_frame_scanout.sv
// Plot-interface receiver plus 640x480@60Hz VGA scan-out of a 160x120x3 framebuffer.
// Each stored pixel is drawn as a 4x4 block of screen pixels.
// Ports:
//   clk, reset                  50 MHz clock, asynchronous active-high reset
//   x, y, colour, plot          pixel write interface; one write per clk while plot=1
//   VGA_R/G/B                   8-bit channels, each replicating its colour bit
//   VGA_HS, VGA_VS              active-low syncs
//   VGA_BLANK_N, VGA_SYNC_N     visible-region flag; sync-on-green tied off
//   VGA_CLK                     25 MHz pixel clock (the pixel enable register)
//   frame_tick                  one-clk pulse at the start of vertical blanking
module vga_frame_scanout
  import vga_frame_scanout_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] x,
  input  logic [6:0] y,
  input  logic [2:0] colour,
  input  logic       plot,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic       VGA_SYNC_N,
  output logic       VGA_CLK,
  output logic       frame_tick
);

  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOT - 1);
  localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOT - 1);
  localparam logic [CNT_W-1:0] H_VIS_C = CNT_W'(H_VIS);
  localparam logic [CNT_W-1:0] V_VIS_C = CNT_W'(V_VIS);
  localparam logic [CNT_W-1:0] V_TICK  = CNT_W'(V_VIS - 1);
  localparam logic [CNT_W-1:0] H_SS    = CNT_W'(H_VIS + H_FP);
  localparam logic [CNT_W-1:0] H_SE    = CNT_W'(H_VIS + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] V_SS    = CNT_W'(V_VIS + V_FP);
  localparam logic [CNT_W-1:0] V_SE    = CNT_W'(V_VIS + V_FP + V_SYNC);
  localparam vid_ctl_t         CTL_IDLE = '{hs: 1'b1, vs: 1'b1, blank_n: 1'b0};

  logic             r_pix_en;
  logic [CNT_W-1:0] r_h_cnt;
  logic [CNT_W-1:0] r_v_cnt;
  vid_ctl_t         r_d1_ctl;
  colour_t          r_d1_rgb;
  logic [7:0]       r_vga_r;
  logic [7:0]       r_vga_g;
  logic [7:0]       r_vga_b;
  vid_ctl_t         r_out_ctl;
  logic             r_frame_tick;

  logic             w_h_last;
  logic             w_v_last;
  vid_ctl_t         w_ctl;
  logic             w_tick;
  fb_addr_t         w_rd_addr;
  colour_t          w_rd_data;
  colour_t          w_pix_colour;
  logic             w_wr_en;
  fb_addr_t         w_wr_addr;

  assign w_h_last = (r_h_cnt == H_LAST);
  assign w_v_last = (r_v_cnt == V_LAST);
  assign w_ctl.blank_n = (r_h_cnt < H_VIS_C) && (r_v_cnt < V_VIS_C);
  assign w_ctl.hs = !((r_h_cnt >= H_SS) && (r_h_cnt < H_SE));
  assign w_ctl.vs = !((r_v_cnt >= V_SS) && (r_v_cnt < V_SE));
  // Fires on the pixel-clock edge that moves the scan from line 479 into line 480
  assign w_tick = r_pix_en && w_h_last && (r_v_cnt == V_TICK);

  // Range check on the raw inputs stops x=160 from spilling into the next row
  assign w_wr_en   = plot && (x < 8'(H_RES)) && (y < 7'(V_RES));
  assign w_wr_addr = fb_addr({1'b0, y}, x);

  // Read address follows the scan only inside the visible window; elsewhere it parks at 0
  always_comb begin
    w_rd_addr = {ADDR_W{1'b0}};
    if (w_ctl.blank_n) begin
      w_rd_addr = fb_addr(r_v_cnt[CNT_W-1:SCALE_SHIFT], r_h_cnt[CNT_W-1:SCALE_SHIFT]);
    end else begin
      w_rd_addr = {ADDR_W{1'b0}};
    end
  end

  // Blanked pixels are forced to black before expansion to 8-bit channels
  assign w_pix_colour = r_d1_ctl.blank_n ? r_d1_rgb : BLACK;

  fb_dual_port_ram u_fb (
    .clk     (clk),
    .i_we    (w_wr_en),
    .i_waddr (w_wr_addr),
    .i_wdata (colour),
    .i_raddr (w_rd_addr),
    .o_rdata (w_rd_data)
  );

  // Pixel-clock divider and the horizontal/vertical scan counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pix_en <= 1'b0;
      r_h_cnt  <= {CNT_W{1'b0}};
      r_v_cnt  <= {CNT_W{1'b0}};
    end else begin
      r_pix_en <= ~r_pix_en;
      if (r_pix_en) begin
        if (w_h_last) begin
          r_h_cnt <= {CNT_W{1'b0}};
          r_v_cnt <= w_v_last ? {CNT_W{1'b0}} : r_v_cnt + 10'd1;
        end else begin
          r_h_cnt <= r_h_cnt + 10'd1;
        end
      end
    end
  end

  // Two pixel-clock stages: RAM data and sync/blank enter stage 1 together, then the pins
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_d1_ctl  <= CTL_IDLE;
      r_d1_rgb  <= BLACK;
      r_out_ctl <= CTL_IDLE;
      r_vga_r   <= 8'h00;
      r_vga_g   <= 8'h00;
      r_vga_b   <= 8'h00;
    end else if (r_pix_en) begin
      // RAM output was read on the preceding clk, so it matches the current counter value
      r_d1_ctl  <= w_ctl;
      r_d1_rgb  <= w_rd_data;
      r_out_ctl <= r_d1_ctl;
      r_vga_r   <= {8{w_pix_colour[2]}};
      r_vga_g   <= {8{w_pix_colour[1]}};
      r_vga_b   <= {8{w_pix_colour[0]}};
    end
  end

  // Registered frame pulse, high for a single clk
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_frame_tick <= 1'b0;
    end else begin
      r_frame_tick <= w_tick;
    end
  end

  assign VGA_R       = r_vga_r;
  assign VGA_G       = r_vga_g;
  assign VGA_B       = r_vga_b;
  assign VGA_HS      = r_out_ctl.hs;
  assign VGA_VS      = r_out_ctl.vs;
  assign VGA_BLANK_N = r_out_ctl.blank_n;
  assign VGA_SYNC_N  = 1'b0;
  assign VGA_CLK     = r_pix_en;
  assign frame_tick  = r_frame_tick;

endmodule
